io_access_arbiter: RTL and testbench

IO_ACCESS_ARBITER -- requirements
Module: io_access_arbiter

---
 rtl/io_access_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_io_access_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_access_arbiter.sv
// CPU programmed-IO vs. four-channel rotating-priority DMA arbiter.
// Sequences each DMA grant through SETUP/XFER/DONE and aborts a stalled XFER after TIMEOUT cycles.
module io_access_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cpu_req,
  input  logic       i_cpu_wr,
  output logic       o_cpu_gnt,
  output logic       o_iorp,
  output logic       o_iowp,
  input  logic [3:0] i_dreq,
  input  logic [3:0] i_dir,
  output logic [3:0] o_dack,
  output logic [1:0] o_aen,
  output logic       o_ior,
  output logic       o_iow,
  input  logic       i_ready_io,
  input  logic       i_ready_mem,
  input  logic       i_cfg_we,
  input  logic [1:0] i_cfg_ch,
  input  logic [3:0] i_cfg_cnt,
  input  logic [3:0] i_cfg_mask,
  output logic [3:0] o_tc,
  output logic       o_busy,
  output logic       o_timeout_err
);

  localparam int unsigned NCH  = 4;
  localparam int unsigned CHW  = 2;
  localparam int unsigned CNTW = 4;
  localparam int unsigned TMOW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CPU   = 3'd1,
    S_SETUP = 3'd2,
    S_XFER  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CHW-1:0]  r_ch, w_ch_nxt;
  logic [CHW-1:0]  r_prio, w_prio_nxt;
  logic [CHW-1:0]  w_sel;
  logic [TMOW-1:0] r_tmo, w_tmo_nxt;
  logic [CNTW-1:0] r_cnt [NCH];
  logic [NCH-1:0]  r_mask;
  logic [NCH-1:0]  w_elig;
  logic            w_found;
  logic            w_done_ok;
  logic            w_abort;

  logic            r_cpu_gnt, w_cpu_gnt_nxt;
  logic            r_iorp, w_iorp_nxt;
  logic            r_iowp, w_iowp_nxt;
  logic [NCH-1:0]  r_dack, w_dack_nxt;
  logic [1:0]      r_aen, w_aen_nxt;
  logic            r_ior, w_ior_nxt;
  logic            r_iow, w_iow_nxt;
  logic [NCH-1:0]  r_tc, w_tc_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_terr, w_terr_nxt;

  // Rotating-priority search starting at r_prio.
  always_comb begin
    w_elig  = '0;
    w_found = 1'b0;
    w_sel   = r_prio;
    for (int unsigned i = 0; i < NCH; i++) begin
      w_elig[i] = i_dreq[i] & ~r_mask[i] & (r_cnt[i] != '0);
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!w_found && w_elig[r_prio + CHW'(i)]) begin
        w_found = 1'b1;
        w_sel   = r_prio + CHW'(i);
      end
    end
  end

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    w_state_nxt   = r_state;
    w_ch_nxt      = r_ch;
    w_prio_nxt    = r_prio;
    w_tmo_nxt     = r_tmo;
    w_done_ok     = 1'b0;
    w_abort       = 1'b0;
    w_cpu_gnt_nxt = 1'b0;
    w_iorp_nxt    = 1'b0;
    w_iowp_nxt    = 1'b0;
    w_dack_nxt    = '0;
    w_aen_nxt     = 2'b00;
    w_ior_nxt     = 1'b0;
    w_iow_nxt     = 1'b0;
    w_tc_nxt      = '0;
    w_busy_nxt    = 1'b0;
    w_terr_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_cpu_req) begin
          w_state_nxt = S_CPU;
        end else if (w_found) begin
          w_state_nxt = S_SETUP;
          w_ch_nxt    = w_sel;
        end
      end
      S_CPU:   w_state_nxt = S_IDLE;
      S_SETUP: begin
        w_state_nxt = S_XFER;
        w_tmo_nxt   = '0;
      end
      S_XFER: begin
        if (i_ready_io && i_ready_mem) begin
          w_state_nxt = S_DONE;
          w_done_ok   = 1'b1;
        end else if (r_tmo == TMOW'(TIMEOUT - 1)) begin
          w_state_nxt = S_DONE;
          w_abort     = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo + TMOW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_prio_nxt  = r_ch + CHW'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
    if (w_state_nxt == S_CPU) begin
      w_cpu_gnt_nxt = 1'b1;
      w_iowp_nxt    = i_cpu_wr;
      w_iorp_nxt    = ~i_cpu_wr;
    end
    if (w_state_nxt == S_SETUP || w_state_nxt == S_XFER) begin
      w_dack_nxt = NCH'(1) << w_ch_nxt;
      w_aen_nxt  = 2'b11;
    end
    if (w_state_nxt == S_XFER) begin
      w_iow_nxt = i_dir[w_ch_nxt];
      w_ior_nxt = ~i_dir[w_ch_nxt];
    end
    // A same-cycle config load of this channel overrides the decrement, so no terminal count.
    if (w_done_ok && r_cnt[r_ch] == CNTW'(1) && !(i_cfg_we && i_cfg_ch == r_ch)) begin
      w_tc_nxt[r_ch] = 1'b1;
    end
    w_terr_nxt = w_abort;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_prio  <= '0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_prio  <= w_prio_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cpu_gnt <= 1'b0;
      r_iorp    <= 1'b0;
      r_iowp    <= 1'b0;
      r_dack    <= '0;
      r_aen     <= 2'b00;
      r_ior     <= 1'b0;
      r_iow     <= 1'b0;
      r_tc      <= '0;
      r_busy    <= 1'b0;
      r_terr    <= 1'b0;
    end else begin
      r_cpu_gnt <= w_cpu_gnt_nxt;
      r_iorp    <= w_iorp_nxt;
      r_iowp    <= w_iowp_nxt;
      r_dack    <= w_dack_nxt;
      r_aen     <= w_aen_nxt;
      r_ior     <= w_ior_nxt;
      r_iow     <= w_iow_nxt;
      r_tc      <= w_tc_nxt;
      r_busy    <= w_busy_nxt;
      r_terr    <= w_terr_nxt;
    end
  end

  // Channel counts and mask; counts saturate at zero, which also disables the channel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mask <= '1;
      for (int unsigned i = 0; i < NCH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      if (i_cfg_we) begin
        r_mask <= i_cfg_mask;
      end
      for (int unsigned i = 0; i < NCH; i++) begin
        if (i_cfg_we && i_cfg_ch == CHW'(i)) begin
          r_cnt[i] <= i_cfg_cnt;
        end else if (w_done_ok && r_ch == CHW'(i) && r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - CNTW'(1);
        end
      end
    end
  end

  assign o_cpu_gnt     = r_cpu_gnt;
  assign o_iorp        = r_iorp;
  assign o_iowp        = r_iowp;
  assign o_dack        = r_dack;
  assign o_aen         = r_aen;
  assign o_ior         = r_ior;
  assign o_iow         = r_iow;
  assign o_tc          = r_tc;
  assign o_busy        = r_busy;
  assign o_timeout_err = r_terr;

endmodule

// File: tb/tb_io_access_arbiter.sv
// Self-checking bench for io_access_arbiter: cycle vector table plus rotation, timeout and reset sequences.
module tb_io_access_arbiter;

  typedef struct packed {
    logic       rst;
    logic       cpu_req;
    logic       cpu_wr;
    logic [3:0] dreq;
    logic [3:0] dir;
    logic       rdy_io;
    logic       rdy_mem;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [3:0] cfg_cnt;
    logic [3:0] cfg_mask;
  } in_t;

  typedef struct packed {
    logic       gnt;
    logic       iorp;
    logic       iowp;
    logic [3:0] dack;
    logic [1:0] aen;
    logic       ior;
    logic       iow;
    logic [3:0] tc;
    logic       busy;
    logic       terr;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t  cur;
  out_t act;
  logic       o_cpu_gnt, o_iorp, o_iowp, o_ior, o_iow, o_busy, o_timeout_err;
  logic [3:0] o_dack, o_tc;
  logic [1:0] o_aen;

  io_access_arbiter #(.TIMEOUT(15)) dut (
    .i_clk         (clk),
    .i_rst         (cur.rst),
    .i_cpu_req     (cur.cpu_req),
    .i_cpu_wr      (cur.cpu_wr),
    .o_cpu_gnt     (o_cpu_gnt),
    .o_iorp        (o_iorp),
    .o_iowp        (o_iowp),
    .i_dreq        (cur.dreq),
    .i_dir         (cur.dir),
    .o_dack        (o_dack),
    .o_aen         (o_aen),
    .o_ior         (o_ior),
    .o_iow         (o_iow),
    .i_ready_io    (cur.rdy_io),
    .i_ready_mem   (cur.rdy_mem),
    .i_cfg_we      (cur.cfg_we),
    .i_cfg_ch      (cur.cfg_ch),
    .i_cfg_cnt     (cur.cfg_cnt),
    .i_cfg_mask    (cur.cfg_mask),
    .o_tc          (o_tc),
    .o_busy        (o_busy),
    .o_timeout_err (o_timeout_err)
  );

  assign act = {o_cpu_gnt, o_iorp, o_iowp, o_dack, o_aen, o_ior, o_iow, o_tc, o_busy, o_timeout_err};

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  out_t sb[$];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic in_t iv(logic rst, logic req, logic wr, logic [3:0] dreq, logic [3:0] dir,
                             logic [1:0] rdy, logic we, logic [1:0] ch, logic [3:0] cnt,
                             logic [3:0] msk);
    in_t r;
    r.rst = rst; r.cpu_req = req; r.cpu_wr = wr; r.dreq = dreq; r.dir = dir;
    r.rdy_io = rdy[1]; r.rdy_mem = rdy[0];
    r.cfg_we = we; r.cfg_ch = ch; r.cfg_cnt = cnt; r.cfg_mask = msk;
    return r;
  endfunction

  function automatic out_t o_idle();
    out_t o = '0;
    return o;
  endfunction

  function automatic out_t o_cpu(logic wr);
    out_t o = '0;
    o.gnt = 1'b1; o.iowp = wr; o.iorp = ~wr; o.busy = 1'b1;
    return o;
  endfunction

  function automatic out_t o_setup(int ch);
    out_t o = '0;
    o.dack = 4'b0001 << ch; o.aen = 2'b11; o.busy = 1'b1;
    return o;
  endfunction

  function automatic out_t o_xfer(int ch, logic d);
    out_t o = o_setup(ch);
    o.iow = d; o.ior = ~d;
    return o;
  endfunction

  function automatic out_t o_done(logic [3:0] tc, logic terr);
    out_t o = '0;
    o.busy = 1'b1; o.tc = tc; o.terr = terr;
    return o;
  endfunction

  task automatic add(input in_t i, input out_t e);
    vec_t v;
    v.in = i; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    int          gq[$];
    int          cur_ch, run, runs, xc, g;
    logic [3:0]  prev_dack, dirv;
    logic        prev_busy, seen;
    out_t        e;

    cur = iv(1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 2'd0, 4'd0, 4'h0);

    // Reset, ch2 read with late ready, CPU-over-DMA, terminal count and reload, CPU read.
    add(iv(1, 0, 0, 4'h0,    4'h0,    2'b00, 0, 2'd0, 4'd0, 4'h0), o_idle());
    add(iv(1, 1, 1, 4'hF,    4'h0,    2'b00, 0, 2'd0, 4'd0, 4'h0), o_idle());
    add(iv(0, 0, 0, 4'b0100, 4'h0,    2'b00, 0, 2'd0, 4'd0, 4'h0), o_idle());
    add(iv(0, 0, 0, 4'h0,    4'h0,    2'b00, 1, 2'd2, 4'd3, 4'h0), o_idle());
    add(iv(0, 0, 0, 4'b0100, 4'h0,    2'b00, 0, 2'd0, 4'd0, 4'h0), o_setup(2));
    add(iv(0, 0, 0, 4'b0100, 4'h0,    2'b00, 0, 2'd0, 4'd0, 4'h0), o_xfer(2, 1'b0));
    add(iv(0, 0, 0, 4'b0100, 4'h0,    2'b00, 0, 2'd0, 4'd0, 4'h0), o_xfer(2, 1'b0));
    add(iv(0, 0, 0, 4'b0100, 4'h0,    2'b11, 0, 2'd0, 4'd0, 4'h0), o_done(4'h0, 1'b0));
    add(iv(0, 0, 0, 4'h0,    4'h0,    2'b00, 0, 2'd0, 4'd0, 4'h0), o_idle());
    add(iv(0, 0, 0, 4'h0,    4'h0,    2'b00, 1, 2'd0, 4'd1, 4'h0), o_idle());
    add(iv(0, 1, 1, 4'b0001, 4'h0,    2'b00, 0, 2'd0, 4'd0, 4'h0), o_cpu(1'b1));
    add(iv(0, 0, 0, 4'b0001, 4'h0,    2'b00, 0, 2'd0, 4'd0, 4'h0), o_idle());
    add(iv(0, 0, 0, 4'b0001, 4'h0,    2'b00, 0, 2'd0, 4'd0, 4'h0), o_setup(0));
    add(iv(0, 0, 0, 4'h0,    4'h0,    2'b11, 0, 2'd0, 4'd0, 4'h0), o_xfer(0, 1'b0));
    add(iv(0, 0, 0, 4'h0,    4'h0,    2'b11, 0, 2'd0, 4'd0, 4'h0), o_done(4'b0001, 1'b0));
    add(iv(0, 0, 0, 4'b0001, 4'h0,    2'b00, 0, 2'd0, 4'd0, 4'h0), o_idle());
    add(iv(0, 0, 0, 4'b0001, 4'h0,    2'b00, 0, 2'd0, 4'd0, 4'h0), o_idle());
    add(iv(0, 0, 0, 4'b0001, 4'h0,    2'b00, 1, 2'd0, 4'd2, 4'h0), o_idle());
    add(iv(0, 0, 0, 4'b0001, 4'b0001, 2'b00, 0, 2'd0, 4'd0, 4'h0), o_setup(0));
    add(iv(0, 0, 0, 4'b0001, 4'b0001, 2'b11, 0, 2'd0, 4'd0, 4'h0), o_xfer(0, 1'b1));
    add(iv(0, 0, 0, 4'h0,    4'b0001, 2'b11, 0, 2'd0, 4'd0, 4'h0), o_done(4'h0, 1'b0));
    add(iv(0, 0, 0, 4'h0,    4'h0,    2'b00, 0, 2'd0, 4'd0, 4'h0), o_idle());
    add(iv(0, 1, 0, 4'h0,    4'h0,    2'b00, 0, 2'd0, 4'd0, 4'h0), o_cpu(1'b0));
    add(iv(0, 0, 0, 4'h0,    4'h0,    2'b00, 0, 2'd0, 4'd0, 4'h0), o_idle());

    #2;
    foreach (vecs[i]) begin
      cur = vecs[i].in;
      sb.push_back(vecs[i].exp);
      tick();
      e = sb.pop_front();
      check($sformatf("vec%0d", i), 32'(act), 32'(e));
    end

    // Rotation: all channels loaded with 5, ready always high.
    cur = iv(1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 2'd0, 4'd0, 4'h0);
    tick();
    for (int ch = 0; ch < 4; ch++) begin
      cur = iv(0, 0, 0, 4'h0, 4'h0, 2'b00, 1, 2'(ch), 4'd5, 4'h0);
      tick();
    end
    dirv = 4'b1010;
    cur = iv(0, 0, 0, 4'hF, dirv, 2'b11, 0, 2'd0, 4'd0, 4'h0);
    gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(3); gq.push_back(0);
    prev_dack = '0; prev_busy = 1'b0; run = 0; runs = 0; cur_ch = 0;
    for (int c = 0; c < 80 && runs < 5; c++) begin
      tick();
      if (o_dack != 4'h0 && prev_dack == 4'h0 && gq.size() > 0) begin
        g = gq.pop_front();
        check("rot_grant", 32'(o_dack), 32'(4'b0001 << g));
        cur_ch = g;
      end
      if (o_ior || o_iow) check("rot_dir", 32'({o_ior, o_iow}), dirv[cur_ch] ? 32'd1 : 32'd2);
      if (o_busy) run++;
      else if (prev_busy) begin
        check("rot_busy_len", 32'(run), 32'd3);
        run = 0;
        runs++;
        if (runs == 5) cur.dreq = 4'h0;
      end
      prev_dack = o_dack;
      prev_busy = o_busy;
    end
    check("rot_complete", 32'(runs), 32'd5);

    // Timeout: memory never ready; ch1 is next in rotation, then ch2.
    cur.dreq = 4'hF; cur.rdy_io = 1'b1; cur.rdy_mem = 1'b0;
    prev_dack = '0; xc = 0; seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      tick();
      if (o_dack != 4'h0 && prev_dack == 4'h0) check("to_grant", 32'(o_dack), 32'h2);
      if (o_ior || o_iow) xc++;
      if (o_timeout_err) begin
        seen = 1'b1;
        check("to_xfer_len", 32'(xc), 32'd15);
        check("to_done_out", 32'(act), 32'(o_done(4'h0, 1'b1)));
      end
      prev_dack = o_dack;
    end
    check("to_seen", 32'(seen), 32'd1);

    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (o_dack != 4'h0) begin
        seen = 1'b1;
        check("to_next_ch", 32'(o_dack), 32'h4);
      end
    end
    check("to_next_seen", 32'(seen), 32'd1);
    tick();
    check("pre_rst_xfer", 32'(act), 32'(o_xfer(2, 1'b0)));

    // Reset in the middle of a transfer.
    cur.rst = 1'b1;
    tick();
    check("rst_mid", 32'(act), 32'(o_idle()));
    cur = iv(0, 0, 0, 4'hF, 4'h0, 2'b11, 0, 2'd0, 4'd0, 4'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("rst_disabled%0d", c), 32'({o_busy, o_dack}), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
